// File: rtl/i2c_reg_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_reg_sequencer
//
// Command-level sequencer for the I2C_Phy master. A single register-access
// request (7-bit device, 8-bit register, 0..MAX_BYTES data bytes) becomes a
// series of Phy handshake ops: Clear / EnQ / ReadCountSet / Write / Read / DeQ.
// A read is a pointer write (device + register) followed by a repeated
// transaction that reads the bytes back.
//
// Handshake (valid/ready style, one op at a time):
//   ASSERT  - exactly one phy_* strobe is high, phy_din is stable, until
//             phy_ack is seen high.
//   RELEASE - every strobe is low until phy_ack is seen low. The next op's
//             strobe rises on the cycle after that.
//   Each phase may last at most ACK_TIMEOUT clocks; when that runs out the
//   strobe drops and the access completes with rsp_err = rsp_timeout = 1.
//   Command side: cmd_valid & cmd_ready accepts a request; cmd_ready is high
//   only while idle. rsp_valid pulses for one clock at completion.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   cmd_valid / cmd_ready   request handshake
//   cmd_rnw                 1 = read, 0 = write
//   cmd_dev, cmd_reg        slave address, register address
//   cmd_len                 byte count 0..MAX_BYTES
//   cmd_wdata               write data, low cmd_len bytes, MS byte sent first
//   rsp_valid               one-cycle completion pulse
//   rsp_err, rsp_timeout    error / timeout cause, held until next accept
//   rsp_rdata               read data, right-aligned, first byte most significant
//   phy_clear .. phy_read   registered Phy op strobes
//   phy_din                 Phy DataIn (device / register / data / read count)
//   phy_dout                Phy DataOut, captured on each DeQ ack
//   phy_ack, phy_nack       Phy handshake acknowledge and slave Nack
//   dbg_state, dbg_release  current FSM state and handshake phase
// -----------------------------------------------------------------------------
module i2c_reg_sequencer #(
   parameter int MAX_BYTES   = 4,
   parameter int ACK_TIMEOUT = 1048576
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic                   cmd_rnw,
   input  logic [6:0]             cmd_dev,
   input  logic [7:0]             cmd_reg,
   input  logic [2:0]             cmd_len,
   input  logic [8*MAX_BYTES-1:0] cmd_wdata,
   output logic                   rsp_valid,
   output logic                   rsp_err,
   output logic                   rsp_timeout,
   output logic [8*MAX_BYTES-1:0] rsp_rdata,
   output logic                   phy_clear,
   output logic                   phy_enq,
   output logic                   phy_deq,
   output logic                   phy_rcset,
   output logic                   phy_write,
   output logic                   phy_read,
   output logic [7:0]             phy_din,
   input  logic [7:0]             phy_dout,
   input  logic                   phy_ack,
   input  logic                   phy_nack,
   output logic [3:0]             dbg_state,
   output logic                   dbg_release
);

   localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMAX = TW'(ACK_TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_CLR   = 4'd1,
      S_EDEV  = 4'd2,
      S_EREG  = 4'd3,
      S_EDAT  = 4'd4,
      S_WGO   = 4'd5,
      S_RCLR  = 4'd6,
      S_REDEV = 4'd7,
      S_RSET  = 4'd8,
      S_RGO   = 4'd9,
      S_DEQ   = 4'd10,
      S_DONE  = 4'd11
   } state_t;

   // strobe vector bit positions
   localparam int B_CLR = 0;
   localparam int B_ENQ = 1;
   localparam int B_DEQ = 2;
   localparam int B_RCS = 3;
   localparam int B_WR  = 4;
   localparam int B_RD  = 5;

   state_t                 state_q, state_d;
   logic                   release_q, release_d;
   logic [TW-1:0]          tmr_q, tmr_d;
   logic [2:0]             cnt_q, cnt_d;
   logic                   rnw_q, rnw_d;
   logic [6:0]             dev_q, dev_d;
   logic [7:0]             reg_addr_q, reg_addr_d;
   logic [2:0]             len_q, len_d;
   logic [8*MAX_BYTES-1:0] wdata_q, wdata_d;
   logic [8*MAX_BYTES-1:0] rdata_q, rdata_d;
   logic                   err_q, err_d;
   logic                   to_q, to_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [5:0]             strobe_q, strobe_d;
   logic [7:0]             din_q, din_d;

   logic                   illegal;
   logic                   op_end;
   logic                   timeout_hit;
   logic [2:0]             cnt_dec;
   logic [2:0]             byte_idx;
   logic [7:0]             data_byte;

   assign illegal = (int'(cmd_len) > MAX_BYTES) || (cmd_rnw && (cmd_len == 3'd0));
   assign cnt_dec = cnt_q - 3'd1;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         release_q   <= 1'b0;
         tmr_q       <= '0;
         cnt_q       <= '0;
         rnw_q       <= 1'b0;
         dev_q       <= '0;
         reg_addr_q  <= '0;
         len_q       <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         to_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         strobe_q    <= '0;
         din_q       <= '0;
      end else begin
         state_q     <= state_d;
         release_q   <= release_d;
         tmr_q       <= tmr_d;
         cnt_q       <= cnt_d;
         rnw_q       <= rnw_d;
         dev_q       <= dev_d;
         reg_addr_q  <= reg_addr_d;
         len_q       <= len_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         to_q        <= to_d;
         rsp_valid_q <= rsp_valid_d;
         strobe_q    <= strobe_d;
         din_q       <= din_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      release_d   = release_q;
      tmr_d       = tmr_q;
      cnt_d       = cnt_q;
      rnw_d       = rnw_q;
      dev_d       = dev_q;
      reg_addr_d  = reg_addr_q;
      len_d       = len_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      to_d        = to_q;
      op_end      = 1'b0;
      timeout_hit = 1'b0;

      case (state_q)
         S_IDLE: begin
            release_d = 1'b0;
            tmr_d     = '0;
            if (cmd_valid) begin
               rnw_d      = cmd_rnw;
               dev_d      = cmd_dev;
               reg_addr_d = cmd_reg;
               len_d      = cmd_len;
               cnt_d      = cmd_len;
               wdata_d    = cmd_wdata;
               rdata_d    = '0;
               to_d       = 1'b0;
               err_d      = illegal;
               state_d    = illegal ? S_DONE : S_CLR;
            end
         end

         S_DONE: begin
            release_d = 1'b0;
            tmr_d     = '0;
            state_d   = S_IDLE;
         end

         default: begin
            if (!release_q) begin
               if (phy_ack) begin
                  release_d = 1'b1;
                  tmr_d     = '0;
                  if (state_q == S_DEQ)
                     rdata_d = {rdata_q[8*MAX_BYTES-9:0], phy_dout};
               end else if (tmr_q == TMAX) begin
                  timeout_hit = 1'b1;
               end else begin
                  tmr_d = tmr_q + TW'(1);
               end
            end else begin
               if (!phy_ack) begin
                  op_end = 1'b1;
               end else if (tmr_q == TMAX) begin
                  timeout_hit = 1'b1;
               end else begin
                  tmr_d = tmr_q + TW'(1);
               end
            end

            if (timeout_hit) begin
               state_d   = S_DONE;
               release_d = 1'b0;
               tmr_d     = '0;
               err_d     = 1'b1;
               to_d      = 1'b1;
            end

            if (op_end) begin
               release_d = 1'b0;
               tmr_d     = '0;
               case (state_q)
                  S_CLR:   state_d = S_EDEV;
                  S_EDEV:  state_d = S_EREG;
                  // reads never enqueue data here; len only counts DeQs for them
                  S_EREG:  state_d = (!rnw_q && cnt_q != 3'd0) ? S_EDAT : S_WGO;
                  S_EDAT: begin
                     cnt_d   = cnt_dec;
                     state_d = (cnt_dec == 3'd0) ? S_WGO : S_EDAT;
                  end
                  S_WGO: begin
                     if (phy_nack) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                     end else begin
                        state_d = rnw_q ? S_RCLR : S_DONE;
                     end
                  end
                  S_RCLR:  state_d = S_REDEV;
                  S_REDEV: state_d = S_RSET;
                  S_RSET:  state_d = S_RGO;
                  S_RGO: begin
                     if (phy_nack) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                     end else begin
                        state_d = S_DEQ;
                     end
                  end
                  S_DEQ: begin
                     cnt_d   = cnt_dec;
                     state_d = (cnt_dec == 3'd0) ? S_DONE : S_DEQ;
                  end
                  default: state_d = S_IDLE;
               endcase
            end
         end
      endcase
   end

   // Data byte for S_EDAT: byte (cnt-1) of the latched write data, so the
   // most significant of the low len bytes goes out first.
   always_comb begin
      byte_idx  = cnt_d - 3'd1;
      data_byte = '0;
      for (int i = 0; i < MAX_BYTES; i++) begin
         if (byte_idx == 3'(i))
            data_byte = wdata_d[8*i +: 8];
      end
   end

   // Strobes and DataIn are registered: they are decoded from the state the
   // FSM enters on this edge, so they change together with the state.
   always_comb begin
      strobe_d    = '0;
      din_d       = '0;
      rsp_valid_d = (state_d == S_DONE);
      if (!release_d) begin
         case (state_d)
            S_CLR, S_RCLR: strobe_d[B_CLR] = 1'b1;
            S_EDEV, S_REDEV: begin
               strobe_d[B_ENQ] = 1'b1;
               din_d           = {1'b0, dev_d};
            end
            S_EREG: begin
               strobe_d[B_ENQ] = 1'b1;
               din_d           = reg_addr_d;
            end
            S_EDAT: begin
               strobe_d[B_ENQ] = 1'b1;
               din_d           = data_byte;
            end
            S_WGO: strobe_d[B_WR] = 1'b1;
            S_RSET: begin
               strobe_d[B_RCS] = 1'b1;
               din_d           = {5'b0, len_d};
            end
            S_RGO: strobe_d[B_RD]  = 1'b1;
            S_DEQ: strobe_d[B_DEQ] = 1'b1;
            default: strobe_d = '0;
         endcase
      end
   end

   assign cmd_ready   = (state_q == S_IDLE);
   assign rsp_valid   = rsp_valid_q;
   assign rsp_err     = err_q;
   assign rsp_timeout = to_q;
   assign rsp_rdata   = rdata_q;
   assign phy_clear   = strobe_q[B_CLR];
   assign phy_enq     = strobe_q[B_ENQ];
   assign phy_deq     = strobe_q[B_DEQ];
   assign phy_rcset   = strobe_q[B_RCS];
   assign phy_write   = strobe_q[B_WR];
   assign phy_read    = strobe_q[B_RD];
   assign phy_din     = din_q;
   assign dbg_state   = state_q;
   assign dbg_release = release_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_i2c_reg_sequencer
//
// Bench for i2c_reg_sequencer. A responder plays the I2C_Phy (random ack
// delays, planned Nacks, read bytes). Each request is turned into the list of
// Phy ops it must produce plus the expected response; the per-cycle monitor
// checks every acked op and every response against that list.
// -----------------------------------------------------------------------------
module tb_i2c_reg_sequencer;

   localparam int MB = 4;
   localparam int TO = 16;

   localparam logic [2:0] OP_CLR = 3'd0;
   localparam logic [2:0] OP_ENQ = 3'd1;
   localparam logic [2:0] OP_DEQ = 3'd2;
   localparam logic [2:0] OP_RCS = 3'd3;
   localparam logic [2:0] OP_WR  = 3'd4;
   localparam logic [2:0] OP_RD  = 3'd5;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          reset;
   logic          cmd_valid, cmd_ready, cmd_rnw;
   logic [6:0]    cmd_dev;
   logic [7:0]    cmd_reg;
   logic [2:0]    cmd_len;
   logic [31:0]   cmd_wdata;
   logic          rsp_valid, rsp_err, rsp_timeout;
   logic [31:0]   rsp_rdata;
   logic          phy_clear, phy_enq, phy_deq, phy_rcset, phy_write, phy_read;
   logic [7:0]    phy_din, phy_dout;
   logic          phy_ack, phy_nack;
   logic [3:0]    dbg_state;
   logic          dbg_release;

   i2c_reg_sequencer #(.MAX_BYTES(MB), .ACK_TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
      .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .rsp_rdata(rsp_rdata),
      .phy_clear(phy_clear), .phy_enq(phy_enq), .phy_deq(phy_deq),
      .phy_rcset(phy_rcset), .phy_write(phy_write), .phy_read(phy_read),
      .phy_din(phy_din), .phy_dout(phy_dout), .phy_ack(phy_ack), .phy_nack(phy_nack),
      .dbg_state(dbg_state), .dbg_release(dbg_release)
   );

   // ---------------- scoreboard ----------------
   int          vectors = 0;
   int          miscompares = 0;
   logic [10:0] exp_q[$];
   logic        exp_pending = 1'b0;
   logic        exp_err, exp_to;
   logic [31:0] exp_rdata;
   int          ops_seen = 0;

   // responder plan
   logic        stuck = 1'b0;
   logic        plan_nack_w = 1'b0;
   logic        plan_nack_r = 1'b0;
   logic [7:0]  rd_q[$];
   int          ack_dly = 0;
   int          rel_dly = 0;
   logic [5:0]  strobes;
   logic [2:0]  mon_op;
   logic [7:0]  mon_din;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected op list and response for one request, straight from the
   // access rules: write = clear, dev, reg, data bytes MS first, write;
   // read = pointer write, then clear, dev, read count, read, len DeQs.
   task automatic model_cmd(input logic rnw, input logic [6:0] dev, input logic [7:0] ra,
                            input int len, input logic [31:0] wdata, input logic nw,
                            input logic nr, input logic [31:0] rb, input logic hang);
      logic [63:0] mask;
      exp_q.delete();
      exp_err   = 1'b0;
      exp_to    = 1'b0;
      exp_rdata = '0;
      if (len > MB || (rnw && len == 0)) begin
         exp_err = 1'b1;
      end else if (hang) begin
         exp_err = 1'b1;
         exp_to  = 1'b1;
      end else begin
         exp_q.push_back({OP_CLR, 8'h00});
         exp_q.push_back({OP_ENQ, 1'b0, dev});
         exp_q.push_back({OP_ENQ, ra});
         if (!rnw)
            for (int i = len - 1; i >= 0; i--) exp_q.push_back({OP_ENQ, wdata[8*i +: 8]});
         exp_q.push_back({OP_WR, 8'h00});
         if (nw) begin
            exp_err = 1'b1;
         end else if (rnw) begin
            exp_q.push_back({OP_CLR, 8'h00});
            exp_q.push_back({OP_ENQ, 1'b0, dev});
            exp_q.push_back({OP_RCS, 8'(len)});
            exp_q.push_back({OP_RD, 8'h00});
            if (nr) begin
               exp_err = 1'b1;
            end else begin
               for (int i = 0; i < len; i++) exp_q.push_back({OP_DEQ, 8'h00});
               mask      = (64'd1 << (8 * len)) - 64'd1;
               exp_rdata = rb & mask[31:0];
            end
         end
      end
   endtask

   // ---------------- Phy responder + per-cycle compare ----------------
   initial begin
      phy_ack  = 1'b0;
      phy_nack = 1'b0;
      phy_dout = 8'h00;
      forever begin
         @(negedge clock);
         strobes = {phy_read, phy_write, phy_rcset, phy_deq, phy_enq, phy_clear};
         check("strobe_onehot", 64'($countones(strobes) <= 1), 64'd1);
         if (reset) begin
            phy_ack  = 1'b0;
            phy_nack = 1'b0;
            ack_dly  = $urandom_range(0, 3);
         end else begin
            if (!phy_ack) begin
               if (strobes != 6'd0 && !stuck) begin
                  if (ack_dly > 0) begin
                     ack_dly--;
                  end else begin
                     if (phy_clear)      mon_op = OP_CLR;
                     else if (phy_enq)   mon_op = OP_ENQ;
                     else if (phy_deq)   mon_op = OP_DEQ;
                     else if (phy_rcset) mon_op = OP_RCS;
                     else if (phy_write) mon_op = OP_WR;
                     else                mon_op = OP_RD;
                     mon_din = (phy_enq || phy_rcset) ? phy_din : 8'h00;
                     if (exp_q.size() == 0) check("op_extra", {mon_op, mon_din}, 64'h7ff);
                     else                   check("op_seq", {mon_op, mon_din}, exp_q.pop_front());
                     ops_seen++;
                     phy_ack = 1'b1;
                     rel_dly = $urandom_range(0, 2);
                     if (phy_write)     phy_nack = plan_nack_w;
                     else if (phy_read) phy_nack = plan_nack_r;
                     else               phy_nack = 1'b0;
                     if (phy_deq) phy_dout = (rd_q.size() != 0) ? rd_q.pop_front() : 8'h00;
                  end
               end
            end else if (strobes == 6'd0) begin
               if (rel_dly > 0) begin
                  rel_dly--;
               end else begin
                  phy_ack = 1'b0;
                  ack_dly = $urandom_range(0, 3);
               end
            end
            if (rsp_valid) begin
               if (!exp_pending) begin
                  check("rsp_unexpected", 64'd1, 64'd0);
               end else begin
                  check("rsp_err", rsp_err, exp_err);
                  check("rsp_timeout", rsp_timeout, exp_to);
                  check("rsp_rdata", rsp_rdata, exp_rdata);
                  check("ops_left", exp_q.size(), 0);
                  exp_pending = 1'b0;
               end
            end
         end
      end
   end

   // ---------------- driver ----------------
   // Called at negedge+1; returns at negedge+1 one cycle after the response.
   task automatic run_cmd(input logic rnw, input logic [6:0] dev, input logic [7:0] ra,
                          input int len, input logic [31:0] wdata, input logic nw,
                          input logic nr, input logic [31:0] rb, input logic hang,
                          input logic hold, output int lat, output int clr_cycles);
      model_cmd(rnw, dev, ra, len, wdata, nw, nr, rb, hang);
      rd_q.delete();
      for (int i = len - 1; i >= 0; i--) rd_q.push_back(rb[8*i +: 8]);
      plan_nack_w = nw;
      plan_nack_r = nr;
      stuck       = hang;
      exp_pending = 1'b1;
      cmd_valid   = 1'b1;
      cmd_rnw     = rnw;
      cmd_dev     = dev;
      cmd_reg     = ra;
      cmd_len     = 3'(len);
      cmd_wdata   = wdata;
      @(negedge clock); #1;
      if (!hold) cmd_valid = 1'b0;
      else check("ready_in_done", cmd_ready, 1'b0);
      lat = 1;
      clr_cycles = 0;
      while (!rsp_valid && lat < 400) begin
         if (phy_clear) clr_cycles++;
         @(negedge clock); #1;
         lat++;
      end
      check("rsp_seen", rsp_valid, 1'b1);
      check("strobes_at_rsp", {phy_read, phy_write, phy_rcset, phy_deq, phy_enq, phy_clear}, 6'd0);
      @(negedge clock); #1;
      cmd_valid = 1'b0;
      stuck     = 1'b0;
      check("rsp_pulse", rsp_valid, 1'b0);
      check("rsp_err_hold", rsp_err, exp_err);
      check("ready_after", cmd_ready, 1'b1);
   endtask

   logic [10:0] lit_w[6];
   int          lat, clr, base;

   initial begin
      reset = 1'b1;
      cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_dev = '0; cmd_reg = '0; cmd_len = '0; cmd_wdata = '0;
      repeat (3) @(negedge clock);
      #1;
      check("reset_ready", cmd_ready, 1'b1);
      check("reset_strobes", {phy_read, phy_write, phy_rcset, phy_deq, phy_enq, phy_clear}, 6'd0);
      check("reset_din", phy_din, 8'h00);
      check("reset_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
      check("reset_rdata", rsp_rdata, 32'h0);
      reset = 1'b0;
      @(negedge clock); #1;

      // directed write: dev 0x1D reg 0x2A len 2 data 0xBEEF
      model_cmd(1'b0, 7'h1D, 8'h2A, 2, 32'h0000BEEF, 1'b0, 1'b0, 32'h0, 1'b0);
      lit_w = '{11'h000, 11'h11D, 11'h12A, 11'h1BE, 11'h1EF, 11'h400};
      check("model_pin_len", exp_q.size(), 6);
      for (int i = 0; i < 6; i++) check("model_pin_op", exp_q[i], lit_w[i]);
      run_cmd(1'b0, 7'h1D, 8'h2A, 2, 32'h0000BEEF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, lat, clr);
      check("wr_err_lit", rsp_err, 1'b0);

      // directed read: dev 0x50 reg 0x10 len 3, slave returns 11,22,33
      run_cmd(1'b1, 7'h50, 8'h10, 3, 32'h0, 1'b0, 1'b0, 32'h00112233, 1'b0, 1'b0, lat, clr);
      check("rd_rdata_lit", rsp_rdata, 32'h00112233);
      check("rd_err_lit", rsp_err, 1'b0);

      // read with Nack on the pointer write
      run_cmd(1'b1, 7'h33, 8'h44, 2, 32'h0, 1'b1, 1'b0, 32'h0000AAAA, 1'b0, 1'b0, lat, clr);
      check("nack_err_lit", {rsp_err, rsp_timeout}, 2'b10);

      // Nack on the read transaction
      run_cmd(1'b1, 7'h21, 8'h05, 4, 32'h0, 1'b0, 1'b1, 32'h01020304, 1'b0, 1'b0, lat, clr);
      check("rnack_rdata_lit", rsp_rdata, 32'h0);

      // Phy never acks: strobe held exactly TO clocks
      run_cmd(1'b0, 7'h0F, 8'h01, 1, 32'h5A, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, lat, clr);
      check("to_strobe_cycles", clr, TO);
      check("to_flags_lit", {rsp_err, rsp_timeout}, 2'b11);

      // illegal requests: response one cycle after accept, no ops
      run_cmd(1'b1, 7'h11, 8'h22, 0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, lat, clr);
      check("ill_len0_lat", lat, 1);
      run_cmd(1'b1, 7'h11, 8'h22, 5, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, lat, clr);
      check("ill_len5_lat", lat, 1);
      check("ill_err_lit", {rsp_err, rsp_timeout}, 2'b10);
      run_cmd(1'b0, 7'h11, 8'h22, 7, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, lat, clr);
      check("ill_len7_lat", lat, 1);

      // pointer-only write
      run_cmd(1'b0, 7'h7F, 8'hFF, 0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, lat, clr);

      // reset in the middle of the data enqueue
      base = ops_seen;
      model_cmd(1'b0, 7'h2C, 8'h80, 4, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 1'b0);
      exp_pending = 1'b1;
      cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_dev = 7'h2C; cmd_reg = 8'h80;
      cmd_len = 3'd4; cmd_wdata = 32'hCAFEF00D;
      @(negedge clock); #1;
      cmd_valid = 1'b0;
      for (int c = 0; c < 200 && ops_seen < base + 4; c++) begin
         @(negedge clock); #1;
      end
      check("mid_edat_reached", 64'(ops_seen >= base + 4), 64'd1);
      reset = 1'b1;
      exp_pending = 1'b0;
      exp_q.delete();
      @(negedge clock); #1;
      check("rst_mid_strobes", {phy_read, phy_write, phy_rcset, phy_deq, phy_enq, phy_clear}, 6'd0);
      check("rst_mid_ready", cmd_ready, 1'b1);
      check("rst_mid_rsp", rsp_valid, 1'b0);
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock); #1;
         check("rst_no_rsp", rsp_valid, 1'b0);
      end
      run_cmd(1'b0, 7'h2C, 8'h80, 4, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, lat, clr);
      check("after_rst_err", rsp_err, 1'b0);

      // randomized requests
      for (int n = 0; n < 40; n++) begin
         logic        r_rnw, r_nw, r_nr;
         int          r_len;
         r_rnw = 1'($urandom_range(0, 1));
         r_len = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
         r_nw  = ($urandom_range(0, 7) == 0);
         r_nr  = ($urandom_range(0, 7) == 0);
         run_cmd(r_rnw, 7'($urandom), 8'($urandom), r_len, $urandom, r_nw, r_nr, $urandom,
                 1'b0, 1'b0, lat, clr);
      end

      repeat (2) @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
